// File: rtl/mio_bus_ws_if.sv
// CPU-side bus of the memory/IO bridge: a level request with its address and data,
// answered by a one-cycle completion pulse with registered read data.
interface mio_bus_ws_if;
  logic        req;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] Cpu_data2bus;
  logic [31:0] Cpu_data4bus;
  logic        MIO_ready;
  logic        bus_err;

  // The master holds req (with mem_w/addr_bus/Cpu_data2bus) until the slave has sampled it.
  // The slave answers every sampled request with exactly one MIO_ready pulse; bus_err marks a failed access.
  modport master (
    output req, mem_w, addr_bus, Cpu_data2bus,
    input  Cpu_data4bus, MIO_ready, bus_err
  );
  modport slave (
    input  req, mem_w, addr_bus, Cpu_data2bus,
    output Cpu_data4bus, MIO_ready, bus_err
  );
endinterface

// File: rtl/mio_bus_ws.sv
// Bridge from the CPU request bus to a fixed-latency RAM and NCH ack-based peripheral
// channels, with an ack timeout that turns a stalled peripheral access into a bus error.
module mio_bus_ws #(
  parameter int NCH     = 4,
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1,
  parameter int TMO     = 15
) (
  input  logic                clk,
  input  logic                rst,
  mio_bus_ws_if.slave         cpu,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_data_in,
  output logic                data_ram_we,
  input  logic [31:0]         ram_data_out,
  output logic [NCH-1:0]      per_sel,
  output logic                per_we,
  output logic                per_rd,
  output logic [31:0]         Peripheral_in,
  input  logic [NCH*32-1:0]   per_rdata,
  input  logic [NCH-1:0]      per_ack,
  output logic [2:0]          dbg_state
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAM_ACC = 3'd1,
    PER_ACC = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic [4:0] NCH_LIM  = 5'(NCH);
  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t            state, state_nx;
  logic [RAM_AW-1:0] ram_word_q;
  logic [3:0]        ch_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              we_q;
  logic [2:0]        lat_cnt;
  logic [7:0]        tmo_cnt;
  logic [NCH-1:0]    ch_sel;
  logic [31:0]       per_slice;
  logic              ack_hit;
  logic              ram_last;
  logic              dec_ram;
  logic              dec_per;
  logic              unused_addr;

  assign dec_ram     = (cpu.addr_bus[31:28] == 4'h0);
  assign dec_per     = (cpu.addr_bus[31:28] == 4'hF) && ({1'b0, cpu.addr_bus[7:4]} < NCH_LIM);
  assign unused_addr = ^cpu.addr_bus;

  // Channel select and read-data slice come from the latched address, so acks and data
  // of every other channel are masked off here.
  always_comb begin
    ch_sel    = '0;
    per_slice = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == 4'(k)) begin
        ch_sel[k] = 1'b1;
        per_slice = per_rdata[32*k +: 32];
      end
    end
  end

  assign ack_hit  = |(per_ack & ch_sel);
  assign ram_last = we_q || (lat_cnt == LAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cpu.req) begin
          if (dec_ram)      state_nx = RAM_ACC;
          else if (dec_per) state_nx = PER_ACC;
          else              state_nx = ERR;
        end
      end
      RAM_ACC: if (ram_last) state_nx = DONE;
      // An ack seen on the timeout cycle still completes the access.
      PER_ACC: begin
        if (ack_hit)                   state_nx = DONE;
        else if (tmo_cnt == TMO_LAST)  state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    data_ram_we      = 1'b0;
    per_sel          = '0;
    per_we           = 1'b0;
    per_rd           = 1'b0;
    cpu.MIO_ready    = 1'b0;
    cpu.bus_err      = 1'b0;
    cpu.Cpu_data4bus = rdata_q;
    case (state)
      RAM_ACC: data_ram_we = we_q;
      PER_ACC: begin
        per_sel = ch_sel;
        per_we  = we_q;
        per_rd  = !we_q;
      end
      DONE: cpu.MIO_ready = 1'b1;
      ERR: begin
        cpu.MIO_ready = 1'b1;
        cpu.bus_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_addr      = ram_word_q;
  assign ram_data_in   = wdata_q;
  assign Peripheral_in = wdata_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_word_q <= '0;
      ch_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      lat_cnt    <= '0;
      tmo_cnt    <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && cpu.req) begin
        ram_word_q <= cpu.addr_bus[RAM_AW+1:2];
        ch_q       <= cpu.addr_bus[7:4];
        wdata_q    <= cpu.Cpu_data2bus;
        we_q       <= cpu.mem_w;
      end
      lat_cnt <= (state == RAM_ACC) ? lat_cnt + 3'd1 : 3'd0;
      tmo_cnt <= (state == PER_ACC) ? tmo_cnt + 8'd1 : 8'd0;
      // Read data is cleared on the way into ERR so the error cycle shows zero.
      if (state_nx == ERR)
        rdata_q <= '0;
      else if (state == RAM_ACC && !we_q && ram_last)
        rdata_q <= ram_data_out;
      else if (state == PER_ACC && !we_q && ack_hit)
        rdata_q <= per_slice;
    end
  end
endmodule

// File: tb/tb_mio_bus_ws.sv
// Bench for mio_bus_ws: reset checks, a table of directed accesses, back-to-back,
// mid-access reset, and random accesses scored against a rule-level model.
module tb_mio_bus_ws;
  localparam int NCH     = 4;
  localparam int RAM_AW  = 10;
  localparam int RAM_LAT = 2;
  localparam int TMO     = 15;

  logic                clk;
  logic                rst;
  logic [RAM_AW-1:0]   ram_addr;
  logic [31:0]         ram_data_in;
  logic                data_ram_we;
  logic [31:0]         ram_data_out;
  logic [NCH-1:0]      per_sel;
  logic                per_we;
  logic                per_rd;
  logic [31:0]         Peripheral_in;
  logic [NCH*32-1:0]   per_rdata;
  logic [NCH-1:0]      per_ack;
  logic [2:0]          dbg_state;

  mio_bus_ws_if bus ();

  mio_bus_ws #(.NCH(NCH), .RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .TMO(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu           (bus),
    .ram_addr      (ram_addr),
    .ram_data_in   (ram_data_in),
    .data_ram_we   (data_ram_we),
    .ram_data_out  (ram_data_out),
    .per_sel       (per_sel),
    .per_we        (per_we),
    .per_rd        (per_rd),
    .Peripheral_in (Peripheral_in),
    .per_rdata     (per_rdata),
    .per_ack       (per_ack),
    .dbg_state     (dbg_state)
  );

  // clock / RAM device
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram_mem [0:1023] = '{default: 32'h0};
  assign ram_data_out = ram_mem[ram_addr];
  always @(posedge clk) if (data_ram_we) ram_mem[ram_addr] <= ram_data_in;

  // scoreboard state
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [0:1023] = '{default: 32'h0};
  logic [31:0] model_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drives one access from a negedge and observes it cycle by cycle until one cycle past ready.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input int ack_d, input logic [31:0] pv, input logic extra,
                         input int exp_rdy, input logic exp_err, input logic [31:0] exp_data,
                         input int exp_strb, input string nm);
    int             rdy_at, strb_n, bad_n, ch;
    logic           err_seen, post_rdy, is_ram, is_per, right, bad;
    logic [31:0]    data_seen;
    logic [NCH-1:0] onehot, acks;
    rdy_at = 0; strb_n = 0; bad_n = 0; err_seen = 1'b0; post_rdy = 1'b1; data_seen = 32'h0;
    ch     = int'(a[7:4]);
    is_ram = (a[31:28] == 4'h0);
    is_per = (a[31:28] == 4'hF) && (ch < NCH);
    onehot = '0;
    if (is_per) onehot[ch] = 1'b1;
    bus.req = 1'b1; bus.mem_w = w; bus.addr_bus = a; bus.Cpu_data2bus = wd;
    for (int j = 0; j < NCH; j++) per_rdata[32*j +: 32] = $urandom;
    if (is_per) per_rdata[32*ch +: 32] = pv;
    per_ack = '0;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0; bus.mem_w = 1'($urandom); bus.addr_bus = $urandom; bus.Cpu_data2bus = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      acks = NCH'($urandom) & ~onehot;
      if (k == ack_d) begin
        acks = acks | onehot;
        if (extra) acks[(ch + 1) % NCH] = 1'b1;
      end
      per_ack = acks;
      #1;
      right = (is_ram && w) ? data_ram_we : (is_per ? (w ? per_we : per_rd) : 1'b0);
      bad = (data_ram_we && !(is_ram && w)) || (per_we && !(is_per && w)) ||
            (per_rd && !(is_per && !w)) ||
            (per_sel != ((per_we || per_rd) ? onehot : '0)) ||
            (data_ram_we && (ram_addr != a[RAM_AW+1:2] || ram_data_in != wd)) ||
            (per_we && Peripheral_in != wd);
      if (right) strb_n++;
      if (bad) bad_n++;
      if (rdy_at != 0) begin
        post_rdy = bus.MIO_ready;
        break;
      end
      if (bus.MIO_ready) begin
        rdy_at    = k;
        err_seen  = bus.bus_err;
        data_seen = bus.Cpu_data4bus;
      end
    end
    per_ack = '0;
    chk({nm, "_ready_cycle"}, rdy_at, exp_rdy);
    chk({nm, "_bus_err"}, 32'(err_seen), 32'(exp_err));
    chk({nm, "_rdata"}, data_seen, exp_data);
    chk({nm, "_strobe_cycles"}, strb_n, exp_strb);
    chk({nm, "_stray_strobe"}, bad_n, 0);
    chk({nm, "_ready_width"}, 32'(post_rdy), 0);
  endtask

  // Reference model: latency, error and returned data straight from the bus rules.
  task automatic predict(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input int ack_d, input logic [31:0] pv,
                         output int rdy, output logic err, output int strb);
    logic [31:0] d;
    int ch;
    ch = int'(a[7:4]);
    if (a[31:28] == 4'h0) begin
      rdy = w ? 2 : RAM_LAT + 1; strb = w ? 1 : 0; err = 1'b0;
      d = w ? model_last : model_mem[a[11:2]];
      if (w) model_mem[a[11:2]] = wd;
    end else if (a[31:28] == 4'hF && ch < NCH) begin
      if (ack_d <= TMO) begin
        rdy = ack_d + 1; strb = ack_d; err = 1'b0; d = w ? model_last : pv;
      end else begin
        rdy = TMO + 1; strb = TMO; err = 1'b1; d = 32'h0;
      end
    end else begin
      rdy = 1; strb = 0; err = 1'b1; d = 32'h0;
    end
    model_last = d;
    exp_q.push_back(d);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          ack_d;
    logic [31:0] pv;
    logic        extra;
    int          rdy;
    logic        err;
    logic [31:0] data;
    int          strb;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int pulses, prev;
    int gaps[$];
    vecs[0]  = '{32'h0000_0010, 1'b1, 32'hCAFE_F00D, 0,  32'h0,         1'b0, 2,  1'b0, 32'h0,         1};
    vecs[1]  = '{32'h0000_0010, 1'b0, 32'h0,         0,  32'h0,         1'b0, 3,  1'b0, 32'hCAFE_F00D, 0};
    vecs[2]  = '{32'hF000_0020, 1'b0, 32'h0,         3,  32'h1234_5678, 1'b0, 4,  1'b0, 32'h1234_5678, 3};
    vecs[3]  = '{32'hF000_0010, 1'b1, 32'hA5A5_A5A5, 0,  32'h0,         1'b0, 16, 1'b1, 32'h0,         15};
    vecs[4]  = '{32'h8000_0000, 1'b0, 32'h0,         0,  32'h0,         1'b0, 1,  1'b1, 32'h0,         0};
    vecs[5]  = '{32'hF000_0050, 1'b0, 32'h0,         0,  32'h0,         1'b0, 1,  1'b1, 32'h0,         0};
    vecs[6]  = '{32'hF000_0030, 1'b0, 32'h0,         15, 32'h0BAD_BEEF, 1'b1, 16, 1'b0, 32'h0BAD_BEEF, 15};
    vecs[7]  = '{32'hF000_0000, 1'b1, 32'h0000_1234, 1,  32'h0,         1'b0, 2,  1'b0, 32'h0BAD_BEEF, 1};
    vecs[8]  = '{32'hF000_0000, 1'b0, 32'h0,         1,  32'h600D_F00D, 1'b0, 2,  1'b0, 32'h600D_F00D, 1};
    vecs[9]  = '{32'h0000_0020, 1'b1, 32'hDEAD_BEEF, 0,  32'h0,         1'b0, 2,  1'b0, 32'h600D_F00D, 1};
    vecs[10] = '{32'h0000_0020, 1'b0, 32'h0,         0,  32'h0,         1'b0, 3,  1'b0, 32'hDEAD_BEEF, 0};
    vecs[11] = '{32'h8000_0004, 1'b1, 32'h1111_2222, 0,  32'h0,         1'b0, 1,  1'b1, 32'h0,         0};

    rst = 1'b1;
    bus.req = 1'b0; bus.mem_w = 1'b0; bus.addr_bus = 32'h0; bus.Cpu_data2bus = 32'h0;
    per_ack = '0; per_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(bus.MIO_ready), 0);
    chk("reset_bus_err", 32'(bus.bus_err), 0);
    chk("reset_rdata", bus.Cpu_data4bus, 0);
    chk("reset_strobes", {per_sel, per_we, per_rd, data_ram_we}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.MIO_ready), 0);

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].ack_d, vecs[i].pv, vecs[i].extra,
              vecs[i].rdy, vecs[i].err, vecs[i].data, vecs[i].strb, $sformatf("vec%0d", i));

    // req held high: RAM writes complete every access length + 2 cycles
    bus.req = 1'b1; bus.mem_w = 1'b1; bus.addr_bus = 32'h14; bus.Cpu_data2bus = 32'h5555_AAAA;
    prev = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.MIO_ready) begin
        if (prev >= 0) gaps.push_back(k - prev);
        prev = k;
      end
    end
    bus.req = 1'b0;
    chk("b2b_pulse_count", 32'(gaps.size() >= 3), 1);
    for (int i = 0; i < 3; i++)
      if (i < gaps.size()) chk($sformatf("b2b_gap%0d", i), gaps[i], 3);
    repeat (4) @(negedge clk);

    // reset in the middle of a peripheral read
    bus.req = 1'b1; bus.mem_w = 1'b0; bus.addr_bus = 32'hF000_0020;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rd_active", 32'(per_rd), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_strobes", {per_sel, per_we, per_rd, data_ram_we}, 0);
    chk("midrst_ready", 32'(bus.MIO_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.MIO_ready) pulses++;
    end
    chk("midrst_no_ready", pulses, 0);
    chk("midrst_rdata", bus.Cpu_data4bus, 0);
    run_txn(32'h0000_0010, 1'b0, 32'h0, 0, 32'h0, 1'b0, 3, 1'b0, 32'hCAFE_F00D, 0, "after_rst");

    // random accesses against the model
    model_last = 32'hCAFE_F00D;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, wd, pv;
      logic        w, e_err;
      int          ack_d, e_rdy, e_strb, kind;
      kind  = $urandom_range(0, 2);
      w     = 1'($urandom);
      wd    = $urandom;
      pv    = $urandom;
      ack_d = $urandom_range(1, TMO + 2);
      if (kind == 0)
        a = 32'h40 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      else if (kind == 1)
        a = 32'hF000_0000 | (32'($urandom_range(0, 5)) << 4) | 32'($urandom_range(0, 15));
      else
        a = (32'($urandom_range(1, 14)) << 28) | 32'($urandom_range(0, 255));
      predict(a, w, wd, ack_d, pv, e_rdy, e_err, e_strb);
      run_txn(a, w, wd, ack_d, pv, 1'($urandom), e_rdy, e_err, exp_q.pop_front(), e_strb,
              $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mio_bus_ws.md
MIO_BUS_WS -- requirements
Module: mio_bus_ws

Interface
REQ-001 Parameter NCH, default 4, number of peripheral channels (1..16).
REQ-002 Parameter RAM_AW, default 10, RAM word-address width.
REQ-003 Parameter RAM_LAT, default 1, RAM read latency in cycles (1..4).
REQ-004 Parameter TMO, default 15, peripheral ack timeout in cycles (1..255).
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req  in  1  CPU access request, level.
REQ-008 mem_w  in  1  1 = write, 0 = read; qualified by req.
REQ-009 addr_bus  in  32  CPU byte address.
REQ-010 Cpu_data2bus  in  32  CPU write data.
REQ-011 Cpu_data4bus  out  32  read data to CPU, registered.
REQ-012 MIO_ready  out  1  one-cycle access-complete pulse.
REQ-013 bus_err  out  1  one-cycle error pulse, coincident with MIO_ready.
REQ-014 ram_addr  out  RAM_AW  RAM word address.
REQ-015 ram_data_in  out  32  RAM write data.
REQ-016 data_ram_we  out  1  RAM write strobe.
REQ-017 ram_data_out  in  32  RAM read data.
REQ-018 per_sel  out  NCH  one-hot channel select.
REQ-019 per_we / per_rd  out  1 each  peripheral write / read strobes.
REQ-020 Peripheral_in  out  32  peripheral write data.
REQ-021 per_rdata  in  NCH*32  read data; channel k at bits [32k+31:32k].
REQ-022 per_ack  in  NCH  per-channel completion ack.

Function
REQ-023 Decode: addr_bus[31:28]=4'h0 -> RAM; 4'hF with addr_bus[7:4] < NCH -> channel addr_bus[7:4]; any other address -> error.
REQ-024 FSM states: IDLE, RAM_ACC, PER_ACC, DONE, ERR.
REQ-025 IDLE: on a clock edge with req=1, latch addr_bus, Cpu_data2bus and mem_w, then go to RAM_ACC, PER_ACC or ERR according to the decode.
REQ-026 ram_addr = latched addr[RAM_AW+1:2]; ram_data_in and Peripheral_in = latched write data.
REQ-027 RAM write: data_ram_we=1 for exactly the single RAM_ACC cycle, then DONE.
REQ-028 RAM read: remain in RAM_ACC for RAM_LAT cycles; capture ram_data_out into Cpu_data4bus on the final edge; then DONE.
REQ-029 PER_ACC: hold per_sel one-hot plus per_we (write) or per_rd (read) until the selected per_ack=1; on that edge capture the channel's per_rdata slice (reads only), then DONE.
REQ-030 Acks from unselected channels are ignored.
REQ-031 Timeout: if no ack has arrived after TMO cycles in PER_ACC, drop the strobes and go to ERR.
REQ-032 An ack arriving in the same cycle as the timeout wins (DONE).
REQ-033 DONE: MIO_ready=1 for one cycle, then IDLE; req is not sampled in DONE.
REQ-034 ERR: MIO_ready=1 and bus_err=1 for one cycle, Cpu_data4bus=0, then IDLE.
REQ-035 Writes leave Cpu_data4bus unchanged.
REQ-036 A new access takes 1 cycle minimum between MIO_ready and the next IDLE sample, so back-to-back requests complete every (access length + 2) cycles.
REQ-037 per_sel, per_we, per_rd and data_ram_we are all 0 outside RAM_ACC/PER_ACC.

Reset
REQ-038 rst=1 forces, asynchronously: state IDLE; Cpu_data4bus=0; MIO_ready, bus_err, data_ram_we, per_we, per_rd=0; per_sel=0; timeout counter=0.
REQ-039 A reset asserted mid-access aborts the access with no ready pulse; the first access after reset release is sampled normally.

Verification
REQ-040 RAM write then read, RAM_LAT=2: write 0x00000010 <- 0xCAFEF00D -> we=1 one cycle with ram_addr=4, ready 2 cycles after sample; read -> Cpu_data4bus=0xCAFEF00D, ready 3 cycles after sample.
REQ-041 Channel 2 read at 0xF0000020, ack after 3 cycles, rdata slice 0x12345678 -> per_sel=4'b0100 with per_rd held 3 cycles, Cpu_data4bus=0x12345678, bus_err=0.
REQ-042 Channel 1 write, ack never given, TMO=15 -> strobes drop after 15 cycles; MIO_ready=bus_err=1 one cycle; Cpu_data4bus=0.
REQ-043 Unmapped addresses 0x80000000 and 0xF0000050 (NCH=4) -> ERR on the next cycle; no strobe ever asserted.
REQ-044 rst pulsed during PER_ACC -> strobes 0 immediately, no MIO_ready; next RAM read completes correctly.
REQ-045 Ack on the same cycle as the timeout, plus a simultaneous ack on an unselected channel -> DONE, bus_err=0, data taken from the selected channel only.
